skid_buffer: RTL and testbench
==============================

SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter INIT, default 0, reset value of both data registers.
REQ-003 Parameter CNT_W, default 16, transfer-counter width; used only with SKID_BUFFER_PERF_EN.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  upstream writer offers in_data.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  WIDTH  upstream data word.
REQ-009 out_valid  output  1  out_data holds a valid word for the downstream reader.
REQ-010 out_ready  input  1  downstream reader accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  head word.
REQ-012 xfer_cnt  output  CNT_W  count of completed output transfers; present only with SKID_BUFFER_PERF_EN.

Function
REQ-013 Input fire SHALL be in_valid & in_ready; output fire SHALL be out_valid & out_ready.
REQ-014 Storage SHALL be two WIDTH-bit registers: main (drives out_data) and skid.
REQ-015 FSM states SHALL be EMPTY (0 words), ONE (main valid), and FULL (main and skid valid).
REQ-016 out_valid SHALL be 1 in ONE and FULL, else 0.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from state only, with no combinational path from out_ready or in_valid.
REQ-018 EMPTY with input fire SHALL load main<=in_data and go to ONE; EMPTY with no input fire SHALL hold.
REQ-019 ONE with input and output fire SHALL load main<=in_data and stay in ONE.
REQ-020 ONE with input fire only SHALL load skid<=in_data and go to FULL.
REQ-021 ONE with output fire only SHALL go to EMPTY, with main unchanged.
REQ-022 ONE with no fire SHALL hold.
REQ-023 FULL with output fire SHALL load main<=skid and go to ONE; FULL with no output fire SHALL hold.
REQ-024 Latency SHALL be one cycle from input fire in EMPTY to out_valid=1 with that word.
REQ-025 Sustained throughput SHALL be one word per cycle when out_ready is held at 1.
REQ-026 Words SHALL leave in acceptance order; none are dropped or duplicated.
REQ-027 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 in_valid in FULL SHALL have no effect; the upstream writer holds its word until in_ready=1.

Reset
REQ-029 While rst=1, the block SHALL immediately, independent of clk, force state=EMPTY, main=skid=INIT, out_valid=0, in_ready=1, out_data=INIT and xfer_cnt=0.
REQ-030 Reset asserted mid-operation SHALL discard all held words without completing any pending transfer.
REQ-031 The first edge after rst deasserts SHALL obey the EMPTY rules of REQ-018.

Configuration
REQ-032 With macro SKID_BUFFER_PERF_EN defined, xfer_cnt SHALL increment by 1 on each output fire and saturate at 2^CNT_W-1.
REQ-033 Without SKID_BUFFER_PERF_EN, the xfer_cnt port and its counter SHALL be absent, and all other behaviour is identical.

Structure
REQ-034 A shared package skid_buffer_pkg SHALL hold the state typedef (EMPTY/ONE/FULL, 2-bit encoding) and the state-count constant.
REQ-035 One sub-module, skid_buffer_ctrl, SHALL contain the FSM, in_ready/out_valid decode and the load enables for main and skid; the datapath registers and counter SHALL stay in the top level.

Verification
REQ-036 Reset: assert rst mid-cycle with FULL holding 0x11,0x22 -> out_valid=0, in_ready=1 and out_data=INIT immediately; after release, no word 0x11/0x22 ever appears.
REQ-037 Single word: in 0xA5 from EMPTY with out_ready=1 -> out_valid=1 and out_data=0xA5 on the next cycle, then EMPTY the cycle after.
REQ-038 Backpressure: out_ready=0 while sending 0x01,0x02,0x03 -> 0x01,0x02 accepted, in_ready=0 in FULL, 0x03 held; then out_ready=1 -> output order 0x01,0x02,0x03.
REQ-039 Streaming: 256 words 0x00..0xFF with in_valid=out_ready=1 -> one word per cycle, in order, in_ready never 0.
REQ-040 Random in_valid/out_ready at 50% for 10000 cycles -> scoreboard matches, and out_data stable whenever out_valid=1 and out_ready=0.
REQ-041 PERF_EN with CNT_W=4: 20 output transfers -> xfer_cnt=15 (saturated); rst -> xfer_cnt=0.

Source files
------------

// File: rtl/skid_buffer_pkg.sv
// Shared types for the skid buffer: FSM state encoding and state count.
package skid_buffer_pkg;

   localparam int unsigned STATE_W    = 2;
   localparam int unsigned NUM_STATES = 3;

   typedef enum logic [STATE_W-1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/skid_buffer_ctrl.sv
// Skid buffer control: occupancy FSM, registered in_ready/out_valid and
// load enables for the main and skid data registers.
module skid_buffer_ctrl
   import skid_buffer_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic out_ready,
   output logic in_ready,
   output logic out_valid,
   output logic load_main_c,
   output logic load_skid_c,
   output logic main_from_skid_c
);

   state_t state;
   logic   in_fire;
   logic   out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Datapath load enables for the edge about to happen
   always_comb begin
      load_main_c      = 1'b0;
      load_skid_c      = 1'b0;
      main_from_skid_c = 1'b0;
      case (state)
         EMPTY: load_main_c = in_fire;
         ONE: begin
            load_main_c = in_fire & out_fire;
            load_skid_c = in_fire & ~out_fire;
         end
         FULL: begin
            load_main_c      = out_fire;
            main_from_skid_c = 1'b1;
         end
         default: ;
      endcase
   end

   // Handshake flags are registered next to state so neither depends on inputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state     <= ONE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b1;
               end
            end
            ONE: begin
               if (in_fire && !out_fire) begin
                  state    <= FULL;
                  in_ready <= 1'b0;
               end else if (!in_fire && out_fire) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state    <= ONE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry skid buffer with fully registered handshakes.
// Define SKID_BUFFER_PERF_EN to add the saturating xfer_cnt output counter.
module skid_buffer
   import skid_buffer_pkg::*;
#(
   parameter int unsigned     WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT = '0
`ifdef SKID_BUFFER_PERF_EN
   ,
   parameter int unsigned     CNT_W = 16
`endif
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef SKID_BUFFER_PERF_EN
   ,
   output logic [CNT_W-1:0] xfer_cnt
`endif
);

   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             load_main_c;
   logic             load_skid_c;
   logic             main_from_skid_c;

   skid_buffer_ctrl u_ctrl (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .out_ready        (out_ready),
      .in_ready         (in_ready),
      .out_valid        (out_valid),
      .load_main_c      (load_main_c),
      .load_skid_c      (load_skid_c),
      .main_from_skid_c (main_from_skid_c)
   );

   // Main always holds the head word; skid catches the one extra word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= INIT;
         skid_q <= INIT;
      end else begin
         if (load_main_c) main_q <= main_from_skid_c ? skid_q : in_data;
         if (load_skid_c) skid_q <= in_data;
      end
   end

   assign out_data = main_q;

`ifdef SKID_BUFFER_PERF_EN
   logic out_fire;
   assign out_fire = out_valid & out_ready;

   // Saturating count of completed output transfers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xfer_cnt <= '0;
      end else if (out_fire && (xfer_cnt != {CNT_W{1'b1}})) begin
         xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Directed and random self-checking bench for skid_buffer.
module tb_skid_buffer;

   localparam logic [7:0] INIT_V = 8'h5A;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
`ifdef SKID_BUFFER_PERF_EN
   logic [3:0] xfer_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   skid_buffer #(
      .WIDTH (8),
      .INIT  (INIT_V)
`ifdef SKID_BUFFER_PERF_EN
      ,
      .CNT_W (4)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef SKID_BUFFER_PERF_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] q[$];
   logic [7:0] next_word;
   logic [7:0] prev_data;
   bit         prev_hold;
   bit         inf;
   bit         outf;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_data", 32'(out_data), 32'(INIT_V));
`ifdef SKID_BUFFER_PERF_EN
      chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("post_rst_empty", 32'(out_valid), 32'd0);

      // single word
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(out_data), 32'hA5);
      tick();
      chk("single_drained", 32'(out_valid), 32'd0);
      chk("single_ready", 32'(in_ready), 32'd1);

      // backpressure
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
      tick();
      chk("bp_one_data", 32'(out_data), 32'h01);
      chk("bp_one_ready", 32'(in_ready), 32'd1);
      in_data = 8'h02;
      tick();
      chk("bp_full_ready", 32'(in_ready), 32'd0);
      chk("bp_full_data", 32'(out_data), 32'h01);
      in_data = 8'h03;
      tick();
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_data", 32'(out_data), 32'h01);
      out_ready = 1'b1;
      tick();
      chk("bp_second", 32'(out_data), 32'h02);
      chk("bp_reopen", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_third", 32'(out_data), 32'h03);
      chk("bp_third_valid", 32'(out_valid), 32'd1);
      tick();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // streaming at full rate
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         in_data = 8'(i);
         tick();
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_data", 32'(out_data), 32'(i));
         chk("stream_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drained", 32'(out_valid), 32'd0);

      // random traffic against a queue model
      next_word = 8'h00;
      prev_hold = 1'b0;
      prev_data = 8'h00;
      for (int c = 0; c < 10000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data   = next_word;
         chk("rand_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("rand_ready", 32'(in_ready), 32'(q.size() < 2));
         if (q.size() > 0) chk("rand_data", 32'(out_data), 32'(q[0]));
         if (prev_hold) chk("rand_stable", 32'(out_data), 32'(prev_data));
         inf  = in_valid && (q.size() < 2);
         outf = out_ready && (q.size() > 0);
         prev_hold = (q.size() > 0) && !out_ready;
         prev_data = out_data;
         if (outf) void'(q.pop_front());
         if (inf) begin
            q.push_back(in_data);
            next_word = next_word + 8'd1;
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick(); tick();
      q.delete();
      chk("rand_drained", 32'(out_valid), 32'd0);

      // reset while full
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
      tick();
      in_data = 8'h22;
      tick();
      in_valid = 1'b0;
      chk("mid_full", 32'(in_ready), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_data", 32'(out_data), 32'(INIT_V));
`ifdef SKID_BUFFER_PERF_EN
      chk("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
`endif
      tick();
      rst = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("after_rst_valid", 32'(out_valid), 32'd0);
         chk("after_rst_data", 32'(out_data), 32'(INIT_V));
      end
      in_valid = 1'b1; in_data = 8'h33;
      tick();
      in_valid = 1'b0;
      chk("after_rst_word", 32'(out_data), 32'h33);
      tick();
      chk("after_rst_end", 32'(out_valid), 32'd0);

`ifdef SKID_BUFFER_PERF_EN
      // counter saturation
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("cnt_cleared", 32'(xfer_cnt), 32'd0);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int w = 0; w < 20; w++) begin
         in_data = 8'(w);
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      chk("cnt_saturated", 32'(xfer_cnt), 32'd15);
      rst = 1'b1;
      #1;
      chk("cnt_reset", 32'(xfer_cnt), 32'd0);
      tick();
      rst = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
